pio_input_capture: RTL

//  Parametrised Avalon-MM input PIO: WIDTH inputs, SYNC_STAGES-deep synchroniser,
//  per-bit rising/falling edge enables, W1C edge capture, masked level IRQ and a

---
 rtl/pio_input_pkg.sv | 28 ++
 rtl/pio_input_debounce.sv | 58 +++++
 rtl/pio_input_capture.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pio_input_pkg.sv
// Shared definitions for the pio_input_capture Avalon-MM input PIO:
// register addresses, write-request payload and debounce counter sizing.
package pio_input_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t ADDR_DATA     = ADDR_W'(0);
    localparam reg_idx_t ADDR_RISE_EN  = ADDR_W'(1);
    localparam reg_idx_t ADDR_IRQ_MASK = ADDR_W'(2);
    localparam reg_idx_t ADDR_CAPTURE  = ADDR_W'(3);
    localparam reg_idx_t ADDR_FALL_EN  = ADDR_W'(4);
    localparam reg_idx_t ADDR_COUNT    = ADDR_W'(5);

    typedef struct packed {
        logic              wr;
        reg_idx_t          addr;
        logic [DATA_W-1:0] data;
    } bus_wr_t;

    // Debounce counter only has to reach DEB_CYCLES-1; never narrower than one bit.
    function automatic int unsigned deb_cnt_w(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/pio_input_debounce.sv
// One input channel: SYNC_STAGES-deep synchroniser followed, when
// PIO_INPUT_DEBOUNCE_EN is defined, by a consecutive-stable-cycles filter.
module pio_input_debounce
    import pio_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
`ifdef PIO_INPUT_DEBOUNCE_EN
    ,
    parameter int unsigned DEB_CYCLES  = 1000
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef PIO_INPUT_DEBOUNCE_EN
    localparam int unsigned DCNT_W = deb_cnt_w(DEB_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);

    logic [DCNT_W-1:0] dcnt_q;
    logic              stable_q;

    // A new level is accepted only after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt_q   <= '0;
            stable_q <= 1'b0;
        end else if (sync_bit == stable_q) begin
            dcnt_q <= '0;
        end else if (dcnt_q == DCNT_LAST) begin
            stable_q <= sync_bit;
            dcnt_q   <= '0;
        end else begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync_bit;
`endif

endmodule

// File: rtl/pio_input_capture.sv
// Avalon-MM input PIO: synchronised inputs, rise/fall edge capture (W1C), masked
// level IRQ and saturating event counter. Debounce enabled by PIO_INPUT_DEBOUNCE_EN.
module pio_input_capture
    import pio_input_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read_n,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bus_wr_t           wr_req;
    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  rise_en_q;
    logic [WIDTH-1:0]  fall_en_q;
    logic [WIDTH-1:0]  irq_mask_q;
    logic [WIDTH-1:0]  capture_q;
    logic [WIDTH-1:0]  capture_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] rdata_d;
    logic [WIDTH-1:0]  ev;
    logic              any_ev;
    logic              wr_rise_en;
    logic              wr_fall_en;
    logic              wr_irq_mask;
    logic              wr_capture;
    logic              wr_count;
    logic              unused_bits;

    assign wr_req.wr   = chipselect & ~write_n;
    assign wr_req.addr = address;
    assign wr_req.data = writedata;

    assign wr_rise_en  = wr_req.wr && (wr_req.addr == ADDR_RISE_EN);
    assign wr_irq_mask = wr_req.wr && (wr_req.addr == ADDR_IRQ_MASK);
    assign wr_capture  = wr_req.wr && (wr_req.addr == ADDR_CAPTURE);
    assign wr_fall_en  = wr_req.wr && (wr_req.addr == ADDR_FALL_EN);
    assign wr_count    = wr_req.wr && (wr_req.addr == ADDR_COUNT);

    // Reads have no side effects and DEB_CYCLES only matters in the debounce build.
    assign unused_bits = ^{read_n, wr_req, 1'(DEB_CYCLES)};

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_input_debounce #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef PIO_INPUT_DEBOUNCE_EN
            ,
            .DEB_CYCLES (DEB_CYCLES)
`endif
        ) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .stable (stable[i])
        );
    end

    // prev tracks stable regardless of enables, so toggling an enable never fakes an edge.
    assign ev     = (stable & ~prev_q & rise_en_q) | (~stable & prev_q & fall_en_q);
    assign any_ev = |ev;

    // Capture: set beats a same-cycle W1C; counter: a clear racing an event lands on 1.
    always_comb begin
        capture_d = capture_q;
        count_d   = count_q;
        if (wr_capture) begin
            capture_d = capture_q & ~wr_req.data[WIDTH-1:0];
        end
        capture_d = capture_d | ev;
        if (wr_count) begin
            count_d = any_ev ? CNT_W'(1) : '0;
        end else if (any_ev && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA:     rdata_d = DATA_W'(stable);
            ADDR_RISE_EN:  rdata_d = DATA_W'(rise_en_q);
            ADDR_IRQ_MASK: rdata_d = DATA_W'(irq_mask_q);
            ADDR_CAPTURE:  rdata_d = DATA_W'(capture_q);
            ADDR_FALL_EN:  rdata_d = DATA_W'(fall_en_q);
            ADDR_COUNT:    rdata_d = DATA_W'(count_q);
            default:       rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_mask_q <= '0;
            capture_q  <= '0;
            count_q    <= '0;
            readdata   <= '0;
        end else begin
            prev_q    <= stable;
            capture_q <= capture_d;
            count_q   <= count_d;
            readdata  <= rdata_d;
            if (wr_rise_en) begin
                rise_en_q <= wr_req.data[WIDTH-1:0];
            end
            if (wr_fall_en) begin
                fall_en_q <= wr_req.data[WIDTH-1:0];
            end
            if (wr_irq_mask) begin
                irq_mask_q <= wr_req.data[WIDTH-1:0];
            end
        end
    end

    assign irq = |(capture_q & irq_mask_q);

endmodule
